// File: rtl/f1_chk_pkg.sv
// f1_chk_pkg: shared constants and types for the f1 sweep checker.
//   GOLDEN_DEF : f1 truth table, bit i = f(i) with i = {a,b,c,d}, a = MSB
//   IDX_W      : width of the vector index (16 vectors)
//   CNT_W      : width of a per-DUT mismatch counter (holds 0..16)
//   state_t    : sweep FSM states
package f1_chk_pkg;

    localparam logic [15:0] GOLDEN_DEF = 16'hE2CE;
    localparam int          IDX_W      = 4;
    localparam int          CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/f1_resp_cmp.sv
// f1_resp_cmp: combinational three-way compare of the DUT outputs against
// the expected f1 value for the current vector.
//   exp_bit   in  expected f1 value
//   o_and_or  in  and-or DUT output
//   o_nand    in  nand-only DUT output
//   o_nor     in  nor-only DUT output
//   mismatch  out {and_or, nand, nor}, 1 = output differs from exp_bit
module f1_resp_cmp (
    input  logic       exp_bit,
    input  logic       o_and_or,
    input  logic       o_nand,
    input  logic       o_nor,
    output logic [2:0] mismatch
);

    // Case inequality: an X or Z on a DUT output is reported as a mismatch
    // rather than silently matching.
    assign mismatch = {(o_and_or !== exp_bit),
                       (o_nand   !== exp_bit),
                       (o_nor    !== exp_bit)};

endmodule

// File: rtl/f1_sweep_checker.sv
// f1_sweep_checker: drives {a,b,c,d} through all 16 vectors, lets each settle
// for SETTLE cycles, then compares the three f1 implementations against the
// golden table and accumulates per-DUT statistics.
//   clk, rst          clock (rising edge), synchronous active-high reset
//   start             begin a sweep (honoured only in IDLE or DONE)
//   o_and_or/o_nand/o_nor  DUT outputs under test
//   a, b, c, d        registered stimulus, {a,b,c,d} = current index
//   busy / done       sweep in progress / results valid and held
//   err_mask          sticky fail flags {and_or, nand, nor}
//   cnt_*             mismatch count per DUT (0..16)
//   first_fail_valid  a mismatch has been seen in this sweep
//   first_fail_idx    index of the first vector with any mismatch
module f1_sweep_checker
    import f1_chk_pkg::*;
#(
    parameter int          SETTLE = 2,
    parameter logic [15:0] GOLDEN = GOLDEN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             o_and_or,
    input  logic             o_nand,
    input  logic             o_nor,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             busy,
    output logic             done,
    output logic [2:0]       err_mask,
    output logic [CNT_W-1:0] cnt_and_or,
    output logic [CNT_W-1:0] cnt_nand,
    output logic [CNT_W-1:0] cnt_nor,
    output logic             first_fail_valid,
    output logic [IDX_W-1:0] first_fail_idx
);

    // Settle counter only needs to reach SETTLE-1.
    localparam int                WCNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = '1;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [WCNT_W-1:0] wcnt;
    logic              exp_bit;
    logic [2:0]        mismatch;

    assign exp_bit = GOLDEN[idx];

    f1_resp_cmp u_cmp (
        .exp_bit  (exp_bit),
        .o_and_or (o_and_or),
        .o_nand   (o_nand),
        .o_nor    (o_nor),
        .mismatch (mismatch)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            idx              <= '0;
            wcnt             <= '0;
            err_mask         <= '0;
            cnt_and_or       <= '0;
            cnt_nand         <= '0;
            cnt_nor          <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state            <= WAIT;
                        idx              <= '0;
                        wcnt             <= '0;
                        err_mask         <= '0;
                        cnt_and_or       <= '0;
                        cnt_nand         <= '0;
                        cnt_nor          <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_idx   <= '0;
                    end
                end
                WAIT: begin
                    wcnt <= wcnt + WCNT_W'(1);
                    // Vector has been on the pins for SETTLE full cycles
                    // by the time CHECK samples it.
                    if (wcnt == WCNT_LAST) state <= CHECK;
                end
                CHECK: begin
                    if (mismatch[2]) cnt_and_or <= cnt_and_or + CNT_W'(1);
                    if (mismatch[1]) cnt_nand   <= cnt_nand   + CNT_W'(1);
                    if (mismatch[0]) cnt_nor    <= cnt_nor    + CNT_W'(1);
                    err_mask <= err_mask | mismatch;
                    if ((|mismatch) && !first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_idx   <= idx;
                    end
                    // Last vector stays on the pins through DONE.
                    if (idx == IDX_LAST) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        wcnt  <= '0;
                        state <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign {a, b, c, d} = idx;
    assign busy         = (state == WAIT) || (state == CHECK);
    assign done         = (state == DONE);

endmodule

// File: tb/tb_f1_sweep_checker.sv
// Bench for f1_sweep_checker: two instances (SETTLE=2 and SETTLE=1) driven
// from per-instance response tables, checked every cycle against a
// timeline model of the sweep plus literal expectations.
module tb_f1_sweep_checker;
    import f1_chk_pkg::*;

    localparam logic [15:0] G    = 16'hE2CE;
    localparam int          SET0 = 2;
    localparam int          SET1 = 1;

    typedef struct packed {
        logic [3:0] idx;
        logic       busy;
        logic       done;
        logic [2:0] err;
        logic [4:0] c_ao;
        logic [4:0] c_nd;
        logic [4:0] c_nr;
        logic       ffv;
        logic [3:0] ffi;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_s [2];
    logic o_ao [2];
    logic o_nd [2];
    logic o_nr [2];
    logic [15:0] tbl  [2][3];
    logic [15:0] mtbl [2][3];
    logic [15:0] snap [2][3];
    logic use_dly [2];
    logic dly_a [2];
    logic dly_b [2];
    logic run [2];
    int   n [2];
    logic cmp_en;
    obs_t obs [2];
    int   errors;
    int   checks;

    logic x0_a, x0_b, x0_c, x0_d, x0_busy, x0_done, x0_ffv;
    logic [2:0] x0_err;
    logic [4:0] x0_cao, x0_cnd, x0_cnr;
    logic [3:0] x0_ffi;
    logic x1_a, x1_b, x1_c, x1_d, x1_busy, x1_done, x1_ffv;
    logic [2:0] x1_err;
    logic [4:0] x1_cao, x1_cnd, x1_cnr;
    logic [3:0] x1_ffi;

    always #5 clk = ~clk;

    f1_sweep_checker #(.SETTLE(SET0), .GOLDEN(G)) dut (
        .clk(clk), .rst(rst), .start(start_s[0]),
        .o_and_or(o_ao[0]), .o_nand(o_nd[0]), .o_nor(o_nr[0]),
        .a(x0_a), .b(x0_b), .c(x0_c), .d(x0_d),
        .busy(x0_busy), .done(x0_done), .err_mask(x0_err),
        .cnt_and_or(x0_cao), .cnt_nand(x0_cnd), .cnt_nor(x0_cnr),
        .first_fail_valid(x0_ffv), .first_fail_idx(x0_ffi)
    );

    f1_sweep_checker #(.SETTLE(SET1), .GOLDEN(G)) dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]),
        .o_and_or(o_ao[1]), .o_nand(o_nd[1]), .o_nor(o_nr[1]),
        .a(x1_a), .b(x1_b), .c(x1_c), .d(x1_d),
        .busy(x1_busy), .done(x1_done), .err_mask(x1_err),
        .cnt_and_or(x1_cao), .cnt_nand(x1_cnd), .cnt_nor(x1_cnr),
        .first_fail_valid(x1_ffv), .first_fail_idx(x1_ffi)
    );

    always_comb begin
        obs[0] = '{idx:{x0_a, x0_b, x0_c, x0_d}, busy:x0_busy, done:x0_done,
                   err:x0_err, c_ao:x0_cao, c_nd:x0_cnd, c_nr:x0_cnr,
                   ffv:x0_ffv, ffi:x0_ffi};
        obs[1] = '{idx:{x1_a, x1_b, x1_c, x1_d}, busy:x1_busy, done:x1_done,
                   err:x1_err, c_ao:x1_cao, c_nd:x1_cnd, c_nr:x1_cnr,
                   ffv:x1_ffv, ffi:x1_ffi};
    end

    // DUT responses: table lookup on the current vector, or a golden
    // response that lags the registered stimulus by one extra cycle.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            o_ao[k] = use_dly[k] ? dly_b[k] : tbl[k][0][obs[k].idx];
            o_nd[k] = tbl[k][1][obs[k].idx];
            o_nr[k] = tbl[k][2][obs[k].idx];
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            dly_a[k] <= G[obs[k].idx];
            dly_b[k] <= dly_a[k];
        end
    end

    // Timeline model: n = edges since the accepted start edge.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int per;
            per = ((k == 0) ? SET0 : SET1) + 1;
            if (rst) begin
                run[k] <= 1'b0;
                n[k]   <= 0;
            end else if (start_s[k] && (!run[k] || n[k] >= 16 * per)) begin
                run[k] <= 1'b1;
                n[k]   <= 0;
                for (int j = 0; j < 3; j++) snap[k][j] <= mtbl[k][j];
            end else if (run[k] && n[k] < 16 * per) begin
                n[k] <= n[k] + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_inst(input int k);
        int per, comp, ie, fi;
        int ce [3];
        logic [2:0] em;
        logic fv, be, de, any;
        string p;
        per = ((k == 0) ? SET0 : SET1) + 1;
        ce = '{0, 0, 0};
        em = '0; fv = 1'b0; fi = 0; be = 1'b0; de = 1'b0; ie = 0; comp = 0;
        if (run[k]) begin
            comp = n[k] / per;
            if (comp > 16) comp = 16;
            ie = (comp > 15) ? 15 : comp;
            be = (n[k] < 16 * per);
            de = !be;
            for (int i = 0; i < comp; i++) begin
                any = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    if (snap[k][j][i] != G[i]) begin
                        ce[j]++;
                        em[2 - j] = 1'b1;
                        any = 1'b1;
                    end
                end
                if (any && !fv) begin
                    fv = 1'b1;
                    fi = i;
                end
            end
        end
        p = (k == 0) ? "s2" : "s1";
        chk({p, ".idx"},  32'(obs[k].idx),  ie);
        chk({p, ".busy"}, 32'(obs[k].busy), 32'(be));
        chk({p, ".done"}, 32'(obs[k].done), 32'(de));
        chk({p, ".err"},  32'(obs[k].err),  32'(em));
        chk({p, ".cao"},  32'(obs[k].c_ao), ce[0]);
        chk({p, ".cnd"},  32'(obs[k].c_nd), ce[1]);
        chk({p, ".cnr"},  32'(obs[k].c_nr), ce[2]);
        chk({p, ".ffv"},  32'(obs[k].ffv),  32'(fv));
        chk({p, ".ffi"},  32'(obs[k].ffi),  fi);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check_inst(0);
            check_inst(1);
        end
    end

    // Structural f1 implementations evaluated per vector.
    function automatic logic f_ao(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return (a & ~c & d) | (~a & ~b & d) | (~a & c) | (b & c);
    endfunction

    function automatic logic f_nand(input logic [3:0] v);
        logic a, b, c, d, na, nb, nc;
        {a, b, c, d} = v;
        na = ~(a & a); nb = ~(b & b); nc = ~(c & c);
        return ~(~(a & nc & d) & ~(na & nb & d) & ~(na & c) & ~(b & c));
    endfunction

    function automatic logic f_nor(input logic [3:0] v);
        logic a, b, c, d, na, nb, nc;
        {a, b, c, d} = v;
        na = ~(a | a); nb = ~(b | b); nc = ~(c | c);
        return ~(~(c | d) | ~(a | nb | c) | ~(na | b | nc));
    endfunction

    task automatic set_tbl(input int k, input logic [15:0] t0, input logic [15:0] t1,
                           input logic [15:0] t2);
        tbl[k][0] = t0;  tbl[k][1] = t1;  tbl[k][2] = t2;
        mtbl[k][0] = t0; mtbl[k][1] = t1; mtbl[k][2] = t2;
        use_dly[k] = 1'b0;
    endtask

    task automatic cyc(input int m);
        repeat (m) @(negedge clk);
    endtask

    task automatic pulse(input int k);
        start_s[k] = 1'b1;
        @(negedge clk);
        start_s[k] = 1'b0;
    endtask

    initial begin
        logic [15:0] t_ao, t_nd, t_nr, sh, m0, m1, m2;
        int per;
        errors = 0; checks = 0; cmp_en = 1'b0;
        start_s[0] = 1'b0; start_s[1] = 1'b0;
        set_tbl(0, G, G, G);
        set_tbl(1, G, G, G);

        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cmp_en = 1'b1;
        chk("rst.busy", 32'(x0_busy), 0);
        chk("rst.cnt",  32'(x0_cao + x0_cnd + x0_cnr), 0);

        // Golden responses: done exactly 48 edges after start.
        pulse(0);
        cyc(47);
        chk("gold.done47", 32'(x0_done), 0);
        cyc(1);
        chk("gold.done48", 32'(x0_done), 1);
        chk("gold.abcd",   32'({x0_a, x0_b, x0_c, x0_d}), 32'hF);
        chk("gold.err",    32'(x0_err), 0);
        chk("gold.ffv",    32'(x0_ffv), 0);

        // Structural gate models.
        for (int i = 0; i < 16; i++) begin
            t_ao[i] = f_ao(4'(i));
            t_nd[i] = f_nand(4'(i));
            t_nr[i] = f_nor(4'(i));
        end
        set_tbl(0, t_ao, t_nd, t_nr);
        pulse(0);
        cyc(48);
        chk("gate.cao", 32'(x0_cao), $countones(t_ao ^ G));
        chk("gate.cnd", 32'(x0_cnd), $countones(t_nd ^ G));
        chk("gate.cnr", 32'(x0_cnr), $countones(t_nr ^ G));

        // nor output stuck at 0.
        set_tbl(0, G, G, 16'h0000);
        pulse(0);
        cyc(48);
        chk("stuck.cnr", 32'(x0_cnr), 9);
        chk("stuck.err", 32'(x0_err), 32'b001);
        chk("stuck.ffi", 32'(x0_ffi), 1);
        chk("stuck.cao", 32'(x0_cao), 0);

        // nand inverted, start re-pulsed while busy.
        set_tbl(0, G, ~G, G);
        pulse(0);
        cyc(9);
        pulse(0);
        cyc(37);
        chk("inv.done47", 32'(x0_done), 0);
        cyc(1);
        chk("inv.done48", 32'(x0_done), 1);
        chk("inv.cnd",    32'(x0_cnd), 16);
        chk("inv.ffi",    32'(x0_ffi), 0);
        chk("inv.err",    32'(x0_err), 32'b010);

        // Reset mid-sweep at cycle 20, then a clean full sweep.
        set_tbl(0, ~G, G, G);
        pulse(0);
        cyc(19);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("mrst.busy", 32'(x0_busy), 0);
        chk("mrst.idx",  32'({x0_a, x0_b, x0_c, x0_d}), 0);
        chk("mrst.cao",  32'(x0_cao), 0);
        chk("mrst.err",  32'(x0_err), 0);
        set_tbl(0, G, G, G);
        pulse(0);
        cyc(47);
        chk("mrst.done47", 32'(x0_done), 0);
        cyc(1);
        chk("mrst.done48", 32'(x0_done), 1);
        chk("mrst.cnt",    32'(x0_cao + x0_cnd + x0_cnr), 0);

        // Response lagging one extra cycle: stale at SETTLE=1, fine at 2.
        set_tbl(0, G, G, G);
        set_tbl(1, G, G, G);
        use_dly[0] = 1'b1;
        use_dly[1] = 1'b1;
        sh[0] = G[0];
        for (int i = 1; i < 16; i++) sh[i] = G[i - 1];
        mtbl[1][0] = sh;
        start_s[0] = 1'b1; start_s[1] = 1'b1;
        cyc(1);
        start_s[0] = 1'b0; start_s[1] = 1'b0;
        cyc(48);
        chk("dly.s1.cao", 32'(x1_cao), 7);
        chk("dly.s1.ffi", 32'(x1_ffi), 1);
        chk("dly.s2.cao", 32'(x0_cao), 0);
        use_dly[0] = 1'b0;
        use_dly[1] = 1'b0;

        // Random fault tables, with start spammed while busy.
        for (int it = 0; it < 10; it++) begin
            int k;
            k = it % 2;
            per = ((k == 0) ? SET0 : SET1) + 1;
            m0 = 16'($urandom & $urandom & $urandom);
            m1 = 16'($urandom & $urandom);
            m2 = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 2) == 0) m1 = 16'h0000;
            set_tbl(k, G ^ m0, G ^ m1, G ^ m2);
            pulse(k);
            for (int m = 1; m < 16 * per; m++) begin
                start_s[k] = ($urandom_range(0, 7) == 0);
                @(negedge clk);
            end
            start_s[k] = 1'b0;
            cyc(1);
            chk("rnd.done", 32'((k == 0) ? x0_done : x1_done), 1);
            chk("rnd.cao",  32'((k == 0) ? x0_cao : x1_cao), $countones(m0));
            cyc(2);
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/f1_sweep_checker.md
Name: f1_sweep_checker

Overview:
- Self-checking stimulus and response stage wrapped around the three f1 implementations (and-or, nand-only, nor-only).
- Upstream role: drives a,b,c,d through all 16 input combinations in order.
- Downstream role: after a programmable settle time, samples the three DUT outputs and compares each against the golden f1 truth table.
- Accumulates per-implementation mismatch statistics and reports completion. Replaces hand-written vector lists in benches.

Parameters:
- SETTLE, 2, clock cycles each vector is held before sampling; must be ≥1 and must exceed the worst gate-path delay in clock periods.
- GOLDEN, 16'hE2CE, expected f1 value per input index {a,b,c,d} (a = MSB). Bit i is f(i), with f = a·c'·d + a'·b'·d + a'·c + b·c.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- o_and_or  in  1  output of the and-or DUT.
- o_nand  in  1  output of the nand DUT.
- o_nor  in  1  output of the nor DUT.
- a, b, c, d  out  1 each  registered stimulus: {a,b,c,d} = idx.
- busy  out  1  high in WAIT and CHECK.
- done  out  1  high in DONE.
- err_mask  out  3  sticky per-DUT fail flag {and_or, nand, nor}.
- cnt_and_or, cnt_nand, cnt_nor  out  5 each  mismatch count per DUT, range 0..16.
- first_fail_valid  out  1  at least one mismatch seen in this sweep.
- first_fail_idx  out  4  idx of the first vector with any mismatch.

Behaviour:
- One clock, clk; reset rst is synchronous and active-high. On rst, all outputs and internal state are 0, state = IDLE. A reset mid-sweep abandons the sweep immediately, with the same values as a reset from IDLE.
- States:
  - IDLE.
  - WAIT: holds the current vector, wcnt counts 0..SETTLE-1.
  - CHECK: one cycle; compares and updates statistics.
  - DONE: results held.
- IDLE/DONE + start=1:
  - idx <= 0; clear err_mask, all counts, first_fail_*; wcnt <= 0; go to WAIT.
  - done deasserts in the same edge.
- WAIT:
  - wcnt++ each cycle.
  - When wcnt == SETTLE-1, go to CHECK.
  - The vector has therefore been stable for SETTLE full cycles before CHECK.
- CHECK:
  - exp = GOLDEN[idx].
  - For each DUT, mismatch if its output ≠ exp. X or Z on a DUT output counts as a mismatch.
  - Each mismatching DUT increments its count and sets its err_mask bit.
  - If any DUT mismatches and first_fail_valid=0, capture first_fail_idx <= idx and set first_fail_valid.
  - If idx == 15, go to DONE with no idx change. Otherwise idx++, wcnt <= 0, go to WAIT.
- Timing:
  - Each vector takes SETTLE+1 cycles.
  - With start sampled at edge k, done is first high after edge k + 16·(SETTLE+1). For SETTLE=2 this is 48 edges after the start edge.
- DONE: results and the last vector (idx=15, a=b=c=d=1) are held until start or rst.
- start while busy is ignored; there is no restart mid-sweep.
- idx never wraps within a sweep.
- Counts cannot overflow: 5 bits covers 16.

Decomposition:
- Package f1_chk_pkg holds:
  - the GOLDEN default constant;
  - IDX_W=4 and CNT_W=5;
  - the state enum {IDLE, WAIT, CHECK, DONE}.
- One natural sub-module, f1_resp_cmp: combinational three-way compare of the DUT outputs against exp, producing a 3-bit mismatch vector with X treated as mismatch. The FSM, counters and capture registers stay in the top.

Test Plan:
- Golden DUT model on all three inputs, start pulse, SETTLE=2 -> done after exactly 48 cycles; err_mask=000; all counts 0; first_fail_valid=0; a..d end at 1111.
- Actual and-or/nand/nor gate modules wired in, clk period 10, SETTLE=2 -> each count equals the number of indices where that DUT differs from 16'hE2CE. The bench computes the expected counts from the gate models' truth tables.
- o_nor stuck at 0, others golden -> cnt_nor=9 (popcount of E2CE); err_mask=001; first_fail_idx=1; other counts 0.
- o_nand inverted golden -> cnt_nand=16, first_fail_idx=0; start pulsed again while busy at cycle 10 -> ignored, sweep length unchanged.
- rst asserted at cycle 20 mid-sweep -> next cycle all outputs 0, state IDLE; a fresh start gives a full 48-cycle sweep with clean counts.
- SETTLE=1 with o_and_or driven from a 1-cycle-delayed golden -> every sample is stale; mismatches land exactly where GOLDEN[idx] ≠ GOLDEN[idx-1] (GOLDEN[0] for idx=0, since the prior vector was 0000). SETTLE=2 -> 0 mismatches.
